// File: rtl/data_memory_controller_pkg.sv
// Shared widths, op codes and IO addresses for the data memory controller.
// Also provides access-length and load-extension helpers.
package data_memory_controller_pkg;

    localparam int XLEN           = 32;
    localparam int INST_OP_WIDTH  = 6;
    localparam int ROB_SIZE_WIDTH = 4;

    localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 6'd0;
    localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 6'd1;
    localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 6'd2;
    localparam logic [INST_OP_WIDTH-1:0] OP_LBU = 6'd3;
    localparam logic [INST_OP_WIDTH-1:0] OP_LHU = 6'd4;
    localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 6'd5;
    localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 6'd6;
    localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 6'd7;

    localparam logic [XLEN-1:0] IO_ADDR_0 = 32'h0003_0000;
    localparam logic [XLEN-1:0] IO_ADDR_1 = 32'h0003_0004;

    // Number of bytes moved on the bus for an op.
    function automatic logic [2:0] op_len(input logic [INST_OP_WIDTH-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_len = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
            default:              op_len = 3'd4;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extend_load(
        input logic [INST_OP_WIDTH-1:0] op,
        input logic [XLEN-1:0]          raw
    );
        case (op)
            OP_LB:   extend_load = {{24{raw[7]}}, raw[7:0]};
            OP_LH:   extend_load = {{16{raw[15]}}, raw[15:0]};
            OP_LBU:  extend_load = {24'd0, raw[7:0]};
            OP_LHU:  extend_load = {16'd0, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    function automatic logic is_io(input logic [XLEN-1:0] addr);
        is_io = (addr == IO_ADDR_0) || (addr == IO_ADDR_1);
    endfunction

endpackage

// File: rtl/data_memory_controller.sv
// Byte-serial memory controller: serialises loads, committed stores and
// instruction fetches onto the 8-bit RAM/IO bus (store > load > fetch).
// Ports:
//   clk, rst (async, active-high), rdy (global enable), flush, io_buffer_full
//   lsb_mem_*      : load request pulse (op/addr/id)
//   rob_mem_*      : committed store pulse (op/addr/data)
//   if_enable/addr : fetch request, level until if_ready
//   mem_busy       : combinational busy for requesters
//   mem_data_ready/mem_data/mem_id : registered load broadcast
//   if_ready/if_inst               : registered fetch result
//   mem_din/mem_dout/mem_a/mem_wr  : RAM bus (mem_wr=1 writes)
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int RAM_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      io_buffer_full,

    input  logic                      lsb_mem_enable,
    input  logic [INST_OP_WIDTH-1:0]  lsb_mem_op,
    input  logic [XLEN-1:0]           lsb_mem_addr,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id,

    input  logic                      rob_mem_enable,
    input  logic [INST_OP_WIDTH-1:0]  rob_mem_op,
    input  logic [XLEN-1:0]           rob_mem_addr,
    input  logic [XLEN-1:0]           rob_mem_data,

    input  logic                      if_enable,
    input  logic [XLEN-1:0]           if_addr,

    output logic                      mem_busy,
    output logic                      mem_data_ready,
    output logic [XLEN-1:0]           mem_data,
    output logic [ROB_SIZE_WIDTH-1:0] mem_id,

    output logic                      if_ready,
    output logic [XLEN-1:0]           if_inst,

    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [XLEN-1:0]           mem_a,
    output logic                      mem_wr
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        STORE_WAIT,
        FETCH
    } state_t;

    localparam logic [2:0] LAT = 3'(RAM_LATENCY);

    state_t                    state;
    logic [2:0]                cnt;
    logic [2:0]                len;
    logic [INST_OP_WIDTH-1:0]  op_q;
    logic [XLEN-1:0]           addr_q;
    logic [XLEN-1:0]           data_q;
    logic [ROB_SIZE_WIDTH-1:0] id_q;
    logic [XLEN-1:0]           rd_buf;
    logic                      wr_q;

    logic                      pend_valid;
    logic [INST_OP_WIDTH-1:0]  pend_op;
    logic [XLEN-1:0]           pend_addr;
    logic [ROB_SIZE_WIDTH-1:0] pend_id;

    logic                      take_pend;
    logic [INST_OP_WIDTH-1:0]  ld_op;
    logic [XLEN-1:0]           ld_addr;
    logic [ROB_SIZE_WIDTH-1:0] ld_id;
    logic [2:0]                cnt_nxt;
    logic [1:0]                cap_idx;
    logic                      cap_en;
    logic                      done;
    logic [XLEN-1:0]           asm_word;

    // In LOAD/FETCH, cnt counts addresses issued; the byte on mem_din
    // belongs to the address issued RAM_LATENCY cycles earlier.
    always_comb begin
        take_pend = pend_valid && !flush;
        ld_op     = take_pend ? pend_op   : lsb_mem_op;
        ld_addr   = take_pend ? pend_addr : lsb_mem_addr;
        ld_id     = take_pend ? pend_id   : lsb_mem_id;
        cnt_nxt   = cnt + 3'd1;
        cap_idx   = 2'(cnt - LAT);
        cap_en    = cnt >= LAT;
        done      = cnt == (len + LAT - 3'd1);
        asm_word  = rd_buf;
        asm_word[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    assign mem_busy = (state != IDLE) || pend_valid ||
                      lsb_mem_enable || rob_mem_enable;

    // Bus is held while stalled, but a write must not repeat.
    assign mem_wr = wr_q && rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 3'd0;
            len            <= 3'd0;
            op_q           <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            id_q           <= '0;
            rd_buf         <= '0;
            wr_q           <= 1'b0;
            pend_valid     <= 1'b0;
            pend_op        <= '0;
            pend_addr      <= '0;
            pend_id        <= '0;
            mem_a          <= '0;
            mem_dout       <= '0;
            mem_data_ready <= 1'b0;
            mem_data       <= '0;
            mem_id         <= '0;
            if_ready       <= 1'b0;
            if_inst        <= '0;
        end else if (rdy) begin
            mem_data_ready <= 1'b0;
            if_ready       <= 1'b0;

            // A load that cannot start now waits in the pending slot.
            if (flush) begin
                pend_valid <= 1'b0;
            end else if (lsb_mem_enable &&
                         (state != IDLE || rob_mem_enable)) begin
                pend_valid <= 1'b1;
                pend_op    <= lsb_mem_op;
                pend_addr  <= lsb_mem_addr;
                pend_id    <= lsb_mem_id;
            end

            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (rob_mem_enable) begin
                        op_q   <= rob_mem_op;
                        addr_q <= rob_mem_addr;
                        data_q <= rob_mem_data;
                        len    <= op_len(rob_mem_op);
                        if (is_io(rob_mem_addr) && io_buffer_full) begin
                            state <= STORE_WAIT;
                        end else begin
                            state    <= STORE;
                            mem_a    <= rob_mem_addr;
                            wr_q     <= 1'b1;
                            mem_dout <= rob_mem_data[7:0];
                        end
                    end else if (take_pend || lsb_mem_enable) begin
                        state  <= LOAD;
                        op_q   <= ld_op;
                        addr_q <= ld_addr;
                        id_q   <= ld_id;
                        len    <= op_len(ld_op);
                        mem_a  <= ld_addr;
                        if (take_pend) pend_valid <= 1'b0;
                    end else if (if_enable && !flush) begin
                        state  <= FETCH;
                        addr_q <= if_addr;
                        len    <= 3'd4;
                        mem_a  <= if_addr;
                    end
                end

                STORE_WAIT: begin
                    if (!io_buffer_full) begin
                        state    <= STORE;
                        cnt      <= 3'd0;
                        mem_a    <= addr_q;
                        wr_q     <= 1'b1;
                        mem_dout <= data_q[7:0];
                    end
                end

                STORE: begin
                    if (cnt == len - 3'd1) begin
                        wr_q <= 1'b0;
                        cnt  <= 3'd0;
                        // Chain straight into a load that arrived with the store.
                        if (take_pend) begin
                            state      <= LOAD;
                            op_q       <= ld_op;
                            addr_q     <= ld_addr;
                            id_q       <= ld_id;
                            len        <= op_len(ld_op);
                            mem_a      <= ld_addr;
                            pend_valid <= 1'b0;
                        end else begin
                            state <= IDLE;
                            mem_a <= '0;
                        end
                    end else begin
                        cnt      <= cnt_nxt;
                        mem_a    <= addr_q + XLEN'(cnt_nxt);
                        mem_dout <= data_q[{cnt_nxt[1:0], 3'b000} +: 8];
                    end
                end

                LOAD, FETCH: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                        mem_a <= '0;
                    end else begin
                        if (cap_en) rd_buf <= asm_word;
                        if (done) begin
                            state <= IDLE;
                            cnt   <= 3'd0;
                            mem_a <= '0;
                            if (state == LOAD) begin
                                mem_data       <= extend_load(op_q, asm_word);
                                mem_id         <= id_q;
                                mem_data_ready <= 1'b1;
                            end else begin
                                if_inst  <= asm_word;
                                if_ready <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_nxt;
                            if (cnt_nxt < len) begin
                                mem_a <= addr_q + XLEN'(cnt_nxt);
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// Scoreboard bench for data_memory_controller: directed cases plus random
// traffic checked against a byte-array reference memory.
module tb_data_memory_controller;
    import data_memory_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, io_buffer_full;
    logic        lsb_mem_enable;
    logic [5:0]  lsb_mem_op;
    logic [31:0] lsb_mem_addr;
    logic [3:0]  lsb_mem_id;
    logic        rob_mem_enable;
    logic [5:0]  rob_mem_op;
    logic [31:0] rob_mem_addr, rob_mem_data;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        mem_busy, mem_data_ready, if_ready, mem_wr;
    logic [31:0] mem_data, if_inst, mem_a;
    logic [3:0]  mem_id;
    logic [7:0]  mem_din, mem_dout;

    data_memory_controller #(.RAM_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .io_buffer_full(io_buffer_full),
        .lsb_mem_enable(lsb_mem_enable), .lsb_mem_op(lsb_mem_op),
        .lsb_mem_addr(lsb_mem_addr), .lsb_mem_id(lsb_mem_id),
        .rob_mem_enable(rob_mem_enable), .rob_mem_op(rob_mem_op),
        .rob_mem_addr(rob_mem_addr), .rob_mem_data(rob_mem_data),
        .if_enable(if_enable), .if_addr(if_addr),
        .mem_busy(mem_busy), .mem_data_ready(mem_data_ready),
        .mem_data(mem_data), .mem_id(mem_id),
        .if_ready(if_ready), .if_inst(if_inst),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          fetch;
        logic [31:0] data;
        logic [3:0]  id;
        int          at;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          at;
    } wr_t;

    res_t rq[$];
    wr_t  wq[$];
    res_t e;
    wr_t  w;

    int checks = 0;
    int errors = 0;
    int io_writes = 0;
    bit mon_on = 0;

    logic [7:0] ram     [0:1023];
    logic [7:0] ref_mem [0:1023];
    logic [5:0] lops [5];
    logic [5:0] sops [3];

    // RAM/IO bus: one cycle read latency, IO writes never reach RAM.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) ram[i] <= ref_mem[i];
        end else if (mem_wr && mem_a != IO_ADDR_0 && mem_a != IO_ADDR_1) begin
            ram[mem_a[9:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[9:0]];
    end

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (mem_data_ready || if_ready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got ready=%b if_ready=%b data %h expected no pulse",
                             mem_data_ready, if_ready, mem_data);
                end else begin
                    e = rq.pop_front();
                    check32("result_kind", {31'd0, if_ready}, {31'd0, e.fetch});
                    check32("result_cycle", cyc, e.at);
                    if (e.fetch) begin
                        check32("if_inst", if_inst, e.data);
                    end else begin
                        check32("load_data", mem_data, e.data);
                        check32("load_id", {28'd0, mem_id}, {28'd0, e.id});
                    end
                end
            end
            if (mem_wr) begin
                if (mem_a == IO_ADDR_0) io_writes++;
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %h@%h expected no write",
                             mem_dout, mem_a);
                end else begin
                    w = wq.pop_front();
                    check32("write_addr", mem_a, w.addr);
                    check32("write_data", {24'd0, mem_dout}, {24'd0, w.data});
                    if (w.at >= 0) check32("write_cycle", cyc, w.at);
                end
            end
        end
    end

    function automatic int mlen(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op,
                                             input logic [31:0] addr);
        logic [31:0] v;
        logic [31:0] a;
        v = 0;
        for (int i = 0; i < mlen(op); i++) begin
            a = addr + 32'(i);
            v = v + (32'(ref_mem[a[9:0]]) << (8 * i));
        end
        if (op == OP_LB && v >= 32'd128)   v = v - 32'd256;
        if (op == OP_LH && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC + $urandom_range(0, 3);
        return 32'($urandom_range(0, 1023));
    endfunction

    task automatic push_store(input logic [5:0] op, input logic [31:0] addr,
                              input logic [31:0] data, input int t);
        wr_t x;
        for (int i = 0; i < mlen(op); i++) begin
            x.addr = addr + 32'(i);
            x.data = 8'(data >> (8 * i));
            x.at   = (t < 0) ? -1 : t + 1 + i;
            wq.push_back(x);
            if (x.addr != IO_ADDR_0 && x.addr != IO_ADDR_1)
                ref_mem[x.addr[9:0]] = x.data;
        end
    endtask

    task automatic push_load(input logic [5:0] op, input logic [31:0] addr,
                             input logic [3:0] id, input int at);
        res_t x;
        x.fetch = 0;
        x.data  = ref_load(op, addr);
        x.id    = id;
        x.at    = at;
        rq.push_back(x);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        rob_mem_enable = 0;
        lsb_mem_enable = 0;
        flush = 0;
    endtask

    task automatic set_load(input logic [5:0] op, input logic [31:0] addr,
                            input logic [3:0] id);
        lsb_mem_enable = 1;
        lsb_mem_op = op;
        lsb_mem_addr = addr;
        lsb_mem_id = id;
    endtask

    task automatic set_store(input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] data);
        rob_mem_enable = 1;
        rob_mem_op = op;
        rob_mem_addr = addr;
        rob_mem_data = data;
    endtask

    task automatic issue_load(input logic [5:0] op, input logic [31:0] addr,
                              input logic [3:0] id, input bit expect_res);
        if (expect_res) push_load(op, addr, id, cyc + mlen(op) + 2);
        set_load(op, addr, id);
        pulse_clear();
    endtask

    task automatic issue_store(input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] data, input bit timed);
        push_store(op, addr, data, timed ? cyc : -1);
        set_store(op, addr, data);
        pulse_clear();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (mem_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: mem_busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int flush_at);
        res_t x;
        int   t;
        bit   got;
        t = cyc;
        got = 0;
        if (flush_at < 0) begin
            x.fetch = 1;
            x.data  = ref_load(OP_LW, addr);
            x.id    = 0;
            x.at    = t + 6;
            rq.push_back(x);
        end
        if_addr = addr;
        if_enable = 1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (flush_at >= 0 && cyc == t + flush_at) begin
                flush = 1;
                if_enable = 0;
                @(negedge clk);
                flush = 0;
                check32("idle_after_fetch_flush", {31'd0, mem_busy}, 32'd0);
                got = 1;
            end else if (if_ready) begin
                got = 1;
            end
        end
        if_enable = 0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: if_ready 0 after 20 cycles, expected 1");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        int kind;
        logic [31:0] a, d, a2, hold;
        logic [5:0] op, op2;

        lops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        sops = '{OP_SB, OP_SH, OP_SW};
        rst = 1; rdy = 1; flush = 0; io_buffer_full = 0;
        lsb_mem_enable = 0; lsb_mem_op = 0; lsb_mem_addr = 0; lsb_mem_id = 0;
        rob_mem_enable = 0; rob_mem_op = 0; rob_mem_addr = 0; rob_mem_data = 0;
        if_enable = 0; if_addr = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        ref_mem[10'h100] = 8'h78; ref_mem[10'h101] = 8'h56;
        ref_mem[10'h102] = 8'h34; ref_mem[10'h103] = 8'h12;
        ref_mem[10'h200] = 8'h80;
        ref_mem[10'h210] = 8'h00; ref_mem[10'h211] = 8'h80;

        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check32("rst_mem_a", mem_a, 32'd0);
        check32("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check32("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check32("rst_ready", {31'd0, mem_data_ready}, 32'd0);
        check32("rst_mem_data", mem_data, 32'd0);
        check32("rst_mem_id", {28'd0, mem_id}, 32'd0);
        check32("rst_if_ready", {31'd0, if_ready}, 32'd0);
        check32("rst_if_inst", if_inst, 32'd0);
        check32("rst_busy", {31'd0, mem_busy}, 32'd0);
        mon_on = 1;

        // LW 0x100, id 5: addresses in t+1..t+4, result in t+6
        push_load(OP_LW, 32'h100, 4'd5, cyc + 6);
        if (ref_load(OP_LW, 32'h100) != 32'h1234_5678) begin
            checks++; errors++;
            $display("FAIL lw_preset: got %h expected 12345678", ref_load(OP_LW, 32'h100));
        end
        set_load(OP_LW, 32'h100, 4'd5);
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            check32("lw_addr", mem_a, 32'h100 + 32'(i));
            @(negedge clk);
        end
        wait_idle();

        issue_load(OP_LB, 32'h200, 4'd1, 1);
        wait_idle();
        issue_load(OP_LBU, 32'h200, 4'd3, 1);
        wait_idle();
        issue_load(OP_LH, 32'h210, 4'd7, 1);
        wait_idle();

        // SH: two writes then idle at t+3
        issue_store(OP_SH, 32'h300, 32'hABCD_1234, 1);
        @(negedge clk);
        @(negedge clk);
        check32("sh_busy_t3", {31'd0, mem_busy}, 32'd0);

        // Store and load together: load addresses start at t+5
        t = cyc;
        push_store(OP_SW, 32'h340, 32'hCAFE_F00D, t);
        push_load(OP_LW, 32'h340, 4'd2, t + 10);
        set_store(OP_SW, 32'h340, 32'hCAFE_F00D);
        set_load(OP_LW, 32'h340, 4'd2);
        pulse_clear();
        repeat (4) @(negedge clk);
        check32("pend_load_addr_t5", mem_a, 32'h340);
        check32("pend_load_wr_t5", {31'd0, mem_wr}, 32'd0);
        wait_idle();

        // IO store held while the UART buffer is full
        io_writes = 0;
        io_buffer_full = 1;
        issue_store(OP_SB, IO_ADDR_0, 32'h0000_005A, 0);
        repeat (3) @(negedge clk);
        check32("io_no_write_while_full", 32'(io_writes), 32'd0);
        check32("io_busy_while_full", {31'd0, mem_busy}, 32'd1);
        io_buffer_full = 0;
        wait_idle();
        check32("io_one_write", 32'(io_writes), 32'd1);

        // Flush during the 2nd byte of an LW
        t = cyc;
        issue_load(OP_LW, 32'h120, 4'd4, 0);
        while (cyc < t + 3) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        check32("idle_after_load_flush", {31'd0, mem_busy}, 32'd0);
        repeat (8) @(negedge clk);

        do_fetch(32'h180, 3);
        repeat (8) @(negedge clk);
        do_fetch(32'h100, -1);
        wait_idle();

        // Flush never shortens a committed store
        issue_store(OP_SW, 32'h360, 32'h1122_3344, 1);
        flush = 1;
        @(negedge clk);
        flush = 0;
        wait_idle();

        // Stall mid-store: bus held, no write while rdy is low
        issue_store(OP_SW, 32'h380, 32'h5566_7788, 0);
        @(posedge clk);
        #1 rdy = 0;
        hold = mem_a;
        @(negedge clk);
        check32("stall_no_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check32("stall_addr_held", mem_a, hold);
        @(posedge clk);
        #1 rdy = 1;
        @(negedge clk);
        wait_idle();

        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 5);
            a  = rand_addr();
            a2 = rand_addr();
            d  = $urandom();
            op  = lops[$urandom_range(0, 4)];
            op2 = sops[$urandom_range(0, 2)];
            case (kind)
                0: issue_store(op2, a, d, 1);
                1: issue_load(op, a, 4'($urandom_range(0, 15)), 1);
                2: begin
                    t = cyc;
                    k = $urandom_range(0, 15);
                    push_store(op2, a, d, t);
                    push_load(op, a2, 4'(k), t + mlen(op2) + mlen(op) + 2);
                    set_store(op2, a, d);
                    set_load(op, a2, 4'(k));
                    pulse_clear();
                end
                3: do_fetch(a, -1);
                4: begin
                    t = cyc;
                    issue_load(op, a, 4'd9, 0);
                    k = $urandom_range(1, mlen(op) + 1);
                    while (cyc < t + k) @(negedge clk);
                    flush = 1;
                    @(negedge clk);
                    flush = 0;
                    check32("idle_after_rand_flush", {31'd0, mem_busy}, 32'd0);
                end
                default: begin
                    issue_store(op2, a, d, 1);
                    flush = 1;
                    @(negedge clk);
                    flush = 0;
                end
            endcase
            wait_idle();
        end

        repeat (10) @(negedge clk);
        check32("results_drained", 32'(rq.size()), 32'd0);
        check32("writes_drained", 32'(wq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_controller.md
# data_memory_controller

Byte-serial memory controller between the load/store buffer, the ROB commit port, the instruction fetcher and the single-port 8-bit RAM/IO bus. It serialises word, half and byte accesses into byte transfers. It sign- or zero-extends load results and broadcasts them on the common data path (`mem_data_ready`/`mem_data`/`mem_id`) that the LSB, RS and ROB snoop. It arbitrates three requesters by fixed priority: store commit, then load, then instruction fetch.

## Interface
- `RAM_LATENCY`, default 1: cycles from `mem_a` presented to the byte valid on `mem_din`. Fixed at 1.
- `clk` in 1: clock. `rst` in 1: reset, asynchronous, active-high. `rdy` in 1: global enable; when low, all state holds.
- `flush` in 1: branch mispredict. `io_buffer_full` in 1: UART output buffer full.
- `lsb_mem_enable` in 1, `lsb_mem_op` in `INST_OP_WIDTH`, `lsb_mem_addr` in `XLEN`, `lsb_mem_id` in `ROB_SIZE_WIDTH`: load request, one-cycle pulse.
- `rob_mem_enable` in 1, `rob_mem_op` in `INST_OP_WIDTH`, `rob_mem_addr` in `XLEN`, `rob_mem_data` in `XLEN`: committed store, one-cycle pulse.
- `if_enable` in 1, `if_addr` in `XLEN`: fetch request, level; held until `if_ready`.
- `mem_busy` out 1: combinational. Equals `state!=IDLE || pending_valid || lsb_mem_enable || rob_mem_enable`.
- `mem_data_ready` out 1, `mem_data` out `XLEN`, `mem_id` out `ROB_SIZE_WIDTH`: load result broadcast, registered.
- `if_ready` out 1, `if_inst` out `XLEN`: fetched instruction, registered.
- `mem_din` in 8, `mem_dout` out 8, `mem_a` out `XLEN`, `mem_wr` out 1: RAM bus. `mem_wr`=1 means write.

## Operation
- States: IDLE, LOAD, STORE, STORE_WAIT, FETCH.
- In each state the block keeps a byte counter `cnt` (0..3) and a total `len`:
  - `len` is 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW/fetch.
- Acceptance in IDLE, in priority order: `rob_mem_enable`, then `pending_valid`, then `lsb_mem_enable`, then `if_enable && !flush`.
- If `rob_mem_enable` and `lsb_mem_enable` arrive together:
  - The store is accepted.
  - The load is latched in a one-entry pending slot (op/addr/id, `pending_valid`=1).
  - The pending load is served when the store finishes.
- A store to 0x30000 or 0x30004 while `io_buffer_full` is high enters STORE_WAIT. It holds there with `mem_wr`=0 until `io_buffer_full` is low, then enters STORE.
- STORE:
  - Drives `mem_a`=addr+cnt, `mem_wr`=1, `mem_dout`=data[8cnt+7:8cnt].
  - After byte `len-1`, goes to IDLE.
- LOAD/FETCH:
  - Drives `mem_a`=addr+cnt, `mem_wr`=0.
  - The byte on `mem_din` in the following cycle is written into buffer byte cnt. Assembly is little-endian.
  - After the last byte is captured:
    - LB/LH results are sign-extended; LBU/LHU results are zero-extended.
    - A load pulses `mem_data_ready` for one cycle with `mem_id`=latched id.
    - A fetch pulses `if_ready` for one cycle.
  - Then returns to IDLE.
- Flush:
  - Aborts LOAD and FETCH. Returns to IDLE, suppresses the result pulse, and clears `pending_valid`.
  - STORE and STORE_WAIT are committed work and always complete.
- Unaligned addresses are not checked; bytes come from addr..addr+len-1 with 32-bit wrap.
- Reset values:
  - State IDLE; `cnt`=0; `pending_valid`=0.
  - Outputs `mem_a`=0, `mem_wr`=0, `mem_dout`=0, `mem_data_ready`=0, `mem_data`=0, `mem_id`=0, `if_ready`=0, `if_inst`=0.

## Timing
- Request pulse in cycle t; the first `mem_a` is driven in t+1.
- Load of len N: addresses in t+1..t+N, bytes in t+2..t+N+1, `mem_data_ready` in t+N+2.
  - LB → t+3; LH → t+4; LW → t+6.
- Fetch: `if_ready` in t+6.
- Store of len N: writes in t+1..t+N. `mem_busy` is low from t+N+1 unless another request is pending.
- `mem_busy` is high in the same cycle as any accepted pulse. This lets the LSB (which issues a cycle after sampling `!mem_busy`) and the ROB never collide.
- Back-to-back: a new request can be accepted in the cycle `mem_data_ready`/`if_ready` is high, because the state is already IDLE.
- `rdy` low freezes all state. The RAM bus is held, with `mem_wr` forced to 0.

## Structure
- Op codes (LB..SW), `XLEN`, `INST_OP_WIDTH`, `ROB_SIZE_WIDTH` and the IO addresses 0x30000/0x30004 belong in `global_params.v`.
- The state encoding is a local `localparam` set.
- No sub-module: the whole block is one module. The pending slot is three registers plus a valid bit.

## Test plan
- LW at 0x100, RAM bytes 0x78,0x56,0x34,0x12, id 5:
  - `mem_a` 0x100..0x103 in t+1..t+4.
  - `mem_data_ready` in t+6 with 0x12345678, `mem_id`=5.
- LB at 0x200 (byte 0x80) → `mem_data`=0xFFFFFF80. LBU → 0x00000080. LH with bytes 0x00,0x80 → 0xFFFF8000.
- SH of 0xABCD1234 at 0x300: `mem_wr`=1 with 0x34@0x300 then 0x12@0x301. `mem_busy` is low at t+3.
- `rob_mem_enable` (SW) and `lsb_mem_enable` (LW, id 2) in the same cycle:
  - Store completes first (t+1..t+4).
  - Load addresses start at t+5.
  - `mem_data_ready` id 2 arrives in t+10.
- SB to 0x30000 with `io_buffer_full`=1 for 3 cycles: no write until it falls; one write of the byte afterwards.
- `flush` during the 2nd byte of an LW, and during a fetch:
  - No `mem_data_ready`/`if_ready` pulse.
  - IDLE the next cycle.
  - A flush during a SW does not cut the write short: all 4 bytes are written.
